// File: rtl/wb_master_cmd.sv
// ==== wb_master_cmd : single-command Wishbone master with ack timeout and error count (rev 1.0) ====
`default_nettype none

`ifndef ADDR_WIDTH
`define ADDR_WIDTH 8
`endif
`ifndef DATA_WIDTH
`define DATA_WIDTH 8
`endif

module wb_master_cmd #(
   parameter int TIMEOUT = 16
) (
   input  logic                     clk_i,
   input  logic                     rst_i,
   // command side
   input  logic                     cmd_valid_i,
   output logic                     cmd_ready_o,
   input  logic                     cmd_we_i,
   input  logic [`ADDR_WIDTH-1:0]   cmd_adr_i,
   input  logic [`DATA_WIDTH-1:0]   cmd_dat_i,
   // response side
   output logic                     rsp_valid_o,
   output logic [`DATA_WIDTH-1:0]   rsp_dat_o,
   output logic                     rsp_err_o,
   output logic [7:0]               err_cnt_o,
   // Wishbone master
   output logic [`ADDR_WIDTH-1:0]   adr_o,
   output logic [`DATA_WIDTH-1:0]   dat_o,
   input  logic [`DATA_WIDTH-1:0]   dat_i,
   output logic                     we_o,
   output logic                     stb_o,
   output logic                     cyc_o,
   input  logic                     ack_i
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_BUS  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   localparam logic [7:0] C_CNT_LAST = 8'(TIMEOUT - 1);

   state_t                    state_q;
   logic                      cmd_ready_q;
   logic                      stb_q;
   logic                      we_q;
   logic [`ADDR_WIDTH-1:0]    adr_q;
   logic [`DATA_WIDTH-1:0]    dat_q;
   logic                      rsp_valid_q;
   logic                      rsp_err_q;
   logic [`DATA_WIDTH-1:0]    rsp_dat_q;
   logic [7:0]                err_cnt_q;
   logic [7:0]                cnt_q;

   logic [7:0]                cnt_d;
   logic [7:0]                err_cnt_d;

   assign cnt_d     = cnt_q + 8'd1;
   assign err_cnt_d = (err_cnt_q == 8'hFF) ? err_cnt_q : err_cnt_q + 8'd1;

   always_ff @(posedge clk_i) begin
      if (!rst_i) begin
         state_q     <= S_IDLE;
         cmd_ready_q <= 1'b0;
         stb_q       <= 1'b0;
         we_q        <= 1'b0;
         adr_q       <= '0;
         dat_q       <= '0;
         rsp_valid_q <= 1'b0;
         rsp_err_q   <= 1'b0;
         rsp_dat_q   <= '0;
         err_cnt_q   <= 8'd0;
         cnt_q       <= 8'd0;
      end else begin
         rsp_valid_q <= 1'b0;
         case (state_q)
            S_IDLE: begin
               // ready is held low for the first cycle after reset release
               if (cmd_ready_q && cmd_valid_i) begin
                  we_q        <= cmd_we_i;
                  adr_q       <= cmd_adr_i;
                  dat_q       <= cmd_we_i ? cmd_dat_i : '0;
                  stb_q       <= 1'b1;
                  cmd_ready_q <= 1'b0;
                  cnt_q       <= 8'd0;
                  state_q     <= S_BUS;
               end else begin
                  cmd_ready_q <= 1'b1;
               end
            end
            S_BUS: begin
               // ack on the last counted cycle still completes as success
               if (ack_i) begin
                  stb_q       <= 1'b0;
                  rsp_valid_q <= 1'b1;
                  rsp_err_q   <= 1'b0;
                  rsp_dat_q   <= we_q ? '0 : dat_i;
                  state_q     <= S_DONE;
               end else if (cnt_q == C_CNT_LAST) begin
                  stb_q       <= 1'b0;
                  rsp_valid_q <= 1'b1;
                  rsp_err_q   <= 1'b1;
                  rsp_dat_q   <= '0;
                  err_cnt_q   <= err_cnt_d;
                  state_q     <= S_DONE;
               end else begin
                  cnt_q       <= cnt_d;
               end
            end
            S_DONE: begin
               cmd_ready_q <= 1'b1;
               state_q     <= S_IDLE;
            end
            default: begin
               stb_q       <= 1'b0;
               cmd_ready_q <= 1'b0;
               state_q     <= S_IDLE;
            end
         endcase
      end
   end

   assign cmd_ready_o = cmd_ready_q;
   assign stb_o       = stb_q;
   assign cyc_o       = stb_q;
   assign we_o        = we_q;
   assign adr_o       = adr_q;
   assign dat_o       = dat_q;
   assign rsp_valid_o = rsp_valid_q;
   assign rsp_err_o   = rsp_err_q;
   assign rsp_dat_o   = rsp_dat_q;
   assign err_cnt_o   = err_cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_wb_master_cmd.sv
// ==== tb_wb_master_cmd : directed bench for wb_master_cmd with a single-register slave (rev 1.0) ====
`default_nettype none

`ifndef ADDR_WIDTH
`define ADDR_WIDTH 8
`endif
`ifndef DATA_WIDTH
`define DATA_WIDTH 8
`endif

module tb_wb_master_cmd;

   logic                     clk_i = 1'b0;
   logic                     rst_i;
   logic                     cmd_valid_i;
   logic                     cmd_ready_o;
   logic                     cmd_we_i;
   logic [`ADDR_WIDTH-1:0]   cmd_adr_i;
   logic [`DATA_WIDTH-1:0]   cmd_dat_i;
   logic                     rsp_valid_o;
   logic [`DATA_WIDTH-1:0]   rsp_dat_o;
   logic                     rsp_err_o;
   logic [7:0]               err_cnt_o;
   logic [`ADDR_WIDTH-1:0]   adr_o;
   logic [`DATA_WIDTH-1:0]   dat_o;
   logic [`DATA_WIDTH-1:0]   dat_i;
   logic                     we_o;
   logic                     stb_o;
   logic                     cyc_o;
   logic                     ack_i;

   int total = 0;
   int bad   = 0;

   // 0: slave, 1: ack tied low, 2: ack on 16th bus cycle only, 3: ack tied high
   logic [1:0]               ack_mode;
   logic [1:0]               slv_cnt;
   logic                     slv_ack;
   logic [`DATA_WIDTH-1:0]   slv_mem = '0;
   int                       bus_cnt = 0;

   always #5 clk_i = ~clk_i;

   wb_master_cmd #(.TIMEOUT(16)) dut (
      .clk_i       (clk_i),
      .rst_i       (rst_i),
      .cmd_valid_i (cmd_valid_i),
      .cmd_ready_o (cmd_ready_o),
      .cmd_we_i    (cmd_we_i),
      .cmd_adr_i   (cmd_adr_i),
      .cmd_dat_i   (cmd_dat_i),
      .rsp_valid_o (rsp_valid_o),
      .rsp_dat_o   (rsp_dat_o),
      .rsp_err_o   (rsp_err_o),
      .err_cnt_o   (err_cnt_o),
      .adr_o       (adr_o),
      .dat_o       (dat_o),
      .dat_i       (dat_i),
      .we_o        (we_o),
      .stb_o       (stb_o),
      .cyc_o       (cyc_o),
      .ack_i       (ack_i)
   );

   // Single-register slave: ack rises two cycles after stb is first seen and
   // stays up until stb is seen low again.
   always @(posedge clk_i) begin
      if (!rst_i || !stb_o) begin
         slv_cnt <= 2'd0;
         slv_ack <= 1'b0;
      end else begin
         if (slv_cnt == 2'd1) slv_ack <= 1'b1;
         if (slv_cnt != 2'd3) slv_cnt <= slv_cnt + 2'd1;
         if (slv_ack && we_o) slv_mem <= dat_o;
      end
   end

   always @(posedge clk_i) bus_cnt <= stb_o ? bus_cnt + 1 : 0;

   assign dat_i = slv_mem;
   assign ack_i = (ack_mode == 2'd0) ? slv_ack :
                  (ack_mode == 2'd1) ? 1'b0 :
                  (ack_mode == 2'd2) ? (stb_o && bus_cnt == 15) : 1'b1;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Issues one command, then keeps cmd_valid high with junk during the bus
   // phase; the DUT must neither latch it nor accept it before DONE.
   task automatic run_cmd(input logic we, input logic [`ADDR_WIDTH-1:0] adr,
                          input logic [`DATA_WIDTH-1:0] dat,
                          output int stb_n, output int lat,
                          output logic [`ADDR_WIDTH-1:0] cap_adr,
                          output logic cap_we,
                          output logic [`DATA_WIDTH-1:0] cap_dat,
                          output int hold_bad);
      int guard;
      stb_n = 0; lat = 0; guard = 0; hold_bad = 0;
      cap_adr = '0; cap_we = 1'b0; cap_dat = '0;
      @(negedge clk_i);
      cmd_valid_i = 1'b1; cmd_we_i = we; cmd_adr_i = adr; cmd_dat_i = dat;
      while (!cmd_ready_o && guard < 10) begin
         @(negedge clk_i);
         guard++;
      end
      if (guard == 10) chk("handshake_wait", 32'(guard), 32'd0);
      do begin
         @(negedge clk_i);
         lat++;
         if (lat == 1) begin
            cap_adr = adr_o; cap_we = we_o; cap_dat = dat_o;
            cmd_we_i = ~we; cmd_adr_i = ~adr; cmd_dat_i = ~dat;
         end
         if (stb_o) begin
            stb_n++;
            if (adr_o !== cap_adr || we_o !== cap_we || dat_o !== cap_dat) hold_bad++;
         end
         if (cyc_o !== stb_o) hold_bad++;
      end while (!rsp_valid_o && lat < 300);
      cmd_valid_i = 1'b0;
      if (lat >= 300) chk("rsp_wait", 32'(lat), 32'd0);
   endtask

   task automatic post_rsp(input string tag);
      @(negedge clk_i);
      chk({tag, "_pulse_end"}, 32'(rsp_valid_o), 32'd0);
      chk({tag, "_stb_idle"},  32'(stb_o),       32'd0);
      chk({tag, "_ready"},     32'(cmd_ready_o), 32'd1);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int                      stb_n, lat, hold_bad;
      logic [`ADDR_WIDTH-1:0]  cap_adr;
      logic                    cap_we;
      logic [`DATA_WIDTH-1:0]  cap_dat;
      int                      hs, rsp, viol, low_run, min_gap, seen_high;

      rst_i = 1'b0; cmd_valid_i = 1'b0; cmd_we_i = 1'b0;
      cmd_adr_i = '0; cmd_dat_i = '0; ack_mode = 2'd0;

      // Reset state
      repeat (3) @(negedge clk_i);
      chk("rst_ready",   32'(cmd_ready_o), 32'd0);
      chk("rst_stb",     32'(stb_o),       32'd0);
      chk("rst_cyc",     32'(cyc_o),       32'd0);
      chk("rst_we",      32'(we_o),        32'd0);
      chk("rst_adr",     32'(adr_o),       32'd0);
      chk("rst_dat",     32'(dat_o),       32'd0);
      chk("rst_rvalid",  32'(rsp_valid_o), 32'd0);
      chk("rst_rerr",    32'(rsp_err_o),   32'd0);
      chk("rst_rdat",    32'(rsp_dat_o),   32'd0);
      chk("rst_errcnt",  32'(err_cnt_o),   32'd0);
      rst_i = 1'b1;
      @(negedge clk_i);
      chk("release_ready", 32'(cmd_ready_o), 32'd1);

      // Write A5 to address 0 through the slave
      run_cmd(1'b1, 'h00, 'hA5, stb_n, lat, cap_adr, cap_we, cap_dat, hold_bad);
      chk("wr_stb_cycles", 32'(stb_n),     32'd3);
      chk("wr_latency",    32'(lat),       32'd4);
      chk("wr_adr",        32'(cap_adr),   32'h00);
      chk("wr_we",         32'(cap_we),    32'd1);
      chk("wr_dat",        32'(cap_dat),   32'hA5);
      chk("wr_hold",       32'(hold_bad),  32'd0);
      chk("wr_err",        32'(rsp_err_o), 32'd0);
      chk("wr_rdat",       32'(rsp_dat_o), 32'h00);
      post_rsp("wr");

      // Read it back
      run_cmd(1'b0, 'h00, 'h5A, stb_n, lat, cap_adr, cap_we, cap_dat, hold_bad);
      chk("rd_stb_cycles", 32'(stb_n),     32'd3);
      chk("rd_latency",    32'(lat),       32'd4);
      chk("rd_we",         32'(cap_we),    32'd0);
      chk("rd_dat_o_zero", 32'(cap_dat),   32'h00);
      chk("rd_hold",       32'(hold_bad),  32'd0);
      chk("rd_rdat",       32'(rsp_dat_o), 32'hA5);
      chk("rd_err",        32'(rsp_err_o), 32'd0);
      post_rsp("rd");

      // Second pattern
      run_cmd(1'b1, 'h07, 'h3C, stb_n, lat, cap_adr, cap_we, cap_dat, hold_bad);
      chk("wr2_adr",       32'(cap_adr),   32'h07);
      chk("wr2_dat",       32'(cap_dat),   32'h3C);
      run_cmd(1'b0, 'h07, 'h00, stb_n, lat, cap_adr, cap_we, cap_dat, hold_bad);
      chk("rd2_rdat",      32'(rsp_dat_o), 32'h3C);

      // Timeout with ack tied low
      ack_mode = 2'd1;
      run_cmd(1'b0, 'h11, 'h00, stb_n, lat, cap_adr, cap_we, cap_dat, hold_bad);
      chk("to_stb_cycles", 32'(stb_n),     32'd16);
      chk("to_latency",    32'(lat),       32'd17);
      chk("to_err",        32'(rsp_err_o), 32'd1);
      chk("to_rdat",       32'(rsp_dat_o), 32'h00);
      chk("to_errcnt",     32'(err_cnt_o), 32'd1);
      chk("to_hold",       32'(hold_bad),  32'd0);
      post_rsp("to");
      repeat (3) @(negedge clk_i);
      chk("to_err_held",   32'(rsp_err_o), 32'd1);
      chk("to_rdat_held",  32'(rsp_dat_o), 32'h00);

      // Ack on the 16th bus cycle beats the timeout
      ack_mode = 2'd2;
      run_cmd(1'b0, 'h22, 'h00, stb_n, lat, cap_adr, cap_we, cap_dat, hold_bad);
      chk("late_stb_cycles", 32'(stb_n),     32'd16);
      chk("late_err",        32'(rsp_err_o), 32'd0);
      chk("late_rdat",       32'(rsp_dat_o), 32'h3C);
      chk("late_errcnt",     32'(err_cnt_o), 32'd1);

      // Ack held high: ignored in IDLE/DONE, immediate success in BUS
      ack_mode = 2'd3;
      viol = 0;
      repeat (4) begin
         @(negedge clk_i);
         if (rsp_valid_o || stb_o) viol++;
      end
      chk("idle_ack_ignored", 32'(viol), 32'd0);
      run_cmd(1'b0, 'h33, 'h00, stb_n, lat, cap_adr, cap_we, cap_dat, hold_bad);
      chk("fast_stb_cycles", 32'(stb_n),     32'd1);
      chk("fast_latency",    32'(lat),       32'd2);
      chk("fast_rdat",       32'(rsp_dat_o), 32'h3C);
      post_rsp("fast");

      // Back-to-back reads with cmd_valid held high
      ack_mode = 2'd0;
      hs = 0; rsp = 0; viol = 0; low_run = 0; min_gap = 99; seen_high = 0;
      cmd_we_i = 1'b0; cmd_adr_i = 'h00; cmd_dat_i = 'h00;
      for (int i = 0; i < 30; i++) begin
         @(negedge clk_i);
         cmd_valid_i = (i < 20);
         if (cmd_valid_i && cmd_ready_o) begin
            hs++;
            if (slv_cnt != 2'd0 || slv_ack) viol++;
         end
         if (rsp_valid_o) begin
            rsp++;
            if (rsp_dat_o !== 'h3C || rsp_err_o) viol++;
         end
         if (stb_o) begin
            if (seen_high && low_run > 0 && low_run < min_gap) min_gap = low_run;
            seen_high = 1;
            low_run = 0;
         end else begin
            low_run++;
         end
      end
      cmd_valid_i = 1'b0;
      chk("b2b_handshakes", 32'(hs),      32'd4);
      chk("b2b_responses",  32'(rsp),     32'd4);
      chk("b2b_min_gap",    32'(min_gap), 32'd2);
      chk("b2b_slave_idle", 32'(viol),    32'd0);

      // Reset on the second bus cycle
      @(negedge clk_i);
      cmd_valid_i = 1'b1; cmd_we_i = 1'b0; cmd_adr_i = 'h00;
      chk("rb_handshake", 32'(cmd_ready_o), 32'd1);
      @(negedge clk_i);
      cmd_valid_i = 1'b0;
      chk("rb_bus1_stb", 32'(stb_o), 32'd1);
      @(negedge clk_i);
      rst_i = 1'b0;
      @(negedge clk_i);
      chk("rb_stb",    32'(stb_o),       32'd0);
      chk("rb_cyc",    32'(cyc_o),       32'd0);
      chk("rb_rvalid", 32'(rsp_valid_o), 32'd0);
      chk("rb_ready",  32'(cmd_ready_o), 32'd0);
      rst_i = 1'b1;
      @(negedge clk_i);
      chk("rb_ready_after", 32'(cmd_ready_o), 32'd1);
      chk("rb_rvalid_after", 32'(rsp_valid_o), 32'd0);
      chk("rb_errcnt",      32'(err_cnt_o),   32'd0);

      // Error counter saturation
      ack_mode = 2'd1;
      for (int i = 0; i < 300; i++) begin
         run_cmd(1'b0, `ADDR_WIDTH'(i), 'h00, stb_n, lat, cap_adr, cap_we, cap_dat, hold_bad);
         if (i == 254) chk("sat_at_255", 32'(err_cnt_o), 32'd255);
      end
      chk("sat_final", 32'(err_cnt_o), 32'd255);
      chk("sat_err",   32'(rsp_err_o), 32'd1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

`default_nettype wire
